// File: rtl/sd_crc7_gen_if.sv
// Serial bit feed and CRC readback between the SD command host and the CRC-7 unit.
// The host side drives bits and enable; the generator side returns the running CRC.
interface sd_crc7_gen_if;
    logic       BITVAL;
    logic       Enable;
    logic [6:0] CRC;

    modport master (
        output BITVAL,
        output Enable,
        input  CRC
    );

    modport slave (
        input  BITVAL,
        input  Enable,
        output CRC
    );
endinterface

// File: rtl/sd_crc7_gen.sv
// Bit-serial CRC-7 (x^7 + x^3 + 1) for the SD command line, MSB first, zero seed,
// no final XOR. CRC is driven straight from the state register.
module sd_crc7_gen (
    input  logic           SD_CLK_IN,
    input  logic           RST_IN,
    sd_crc7_gen_if.slave   crc_bus
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       inv;

    // Feedback term is folded into bit 0 and bit 3, matching the x^0 and x^3 taps.
    always_comb begin
        inv   = crc_bus.BITVAL ^ crc_q[6];
        crc_d = crc_q;
        if (crc_bus.Enable) begin
            crc_d = {crc_q[5:3], crc_q[2] ^ inv, crc_q[1:0], inv};
        end
    end

    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            crc_q <= 7'd0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_bus.CRC = crc_q;

endmodule

// File: tb/tb_sd_crc7_gen.sv
// Bench for sd_crc7_gen: directed SD commands plus random messages checked against
// a polynomial long-division model of CRC-7.
module tb_sd_crc7_gen;

    logic SD_CLK_IN;
    logic RST_IN;

    sd_crc7_gen_if bif ();

    sd_crc7_gen dut (
        .SD_CLK_IN (SD_CLK_IN),
        .RST_IN    (RST_IN),
        .crc_bus   (bif)
    );

    int total = 0;
    int bad   = 0;
    bit msg[$];

    initial SD_CLK_IN = 1'b0;
    always #5 SD_CLK_IN = ~SD_CLK_IN;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1, by plain long division.
    function automatic logic [6:0] ref_crc();
        bit         a[$];
        bit [7:0]   poly;
        logic [6:0] r;
        poly = 8'b1000_1001;
        a = msg;
        repeat (7) a.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++) begin
            if (a[i]) begin
                for (int j = 0; j < 8; j++) a[i+j] = a[i+j] ^ poly[7-j];
            end
        end
        for (int k = 0; k < 7; k++) r[6-k] = a[msg.size()+k];
        return r;
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs sampled there too.
    task automatic clk_bit(input bit b, input bit en);
        bif.BITVAL = b;
        bif.Enable = en;
        if (en && !RST_IN) msg.push_back(b);
        @(posedge SD_CLK_IN);
        #1;
    endtask

    task automatic feed_bit(input bit b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) clk_bit(1'($urandom), 1'b0);
        end
        clk_bit(b, 1'b1);
    endtask

    task automatic feed_word(input logic [39:0] w, input bit gaps);
        for (int i = 39; i >= 0; i--) feed_bit(w[i], gaps);
    endtask

    task automatic do_reset();
        RST_IN = 1'b1;
        #3;
        RST_IN = 1'b0;
        msg.delete();
    endtask

    initial begin
        logic [6:0] held;
        logic [6:0] seven;
        int         len;

        RST_IN     = 1'b1;
        bif.BITVAL = 1'b0;
        bif.Enable = 1'b0;
        @(posedge SD_CLK_IN);
        #1;
        check_val("reset_initial", bif.CRC, 7'h00);
        RST_IN = 1'b0;

        // Single bit then a zero bit.
        clk_bit(1'b1, 1'b1);
        check_val("single_one", bif.CRC, 7'h09);
        clk_bit(1'b0, 1'b1);
        check_val("one_then_zero", bif.CRC, 7'h12);

        // Hold with Enable low while BITVAL toggles.
        held = bif.CRC;
        for (int i = 0; i < 10; i++) begin
            clk_bit(1'(i & 1), 1'b0);
            check_val("hold", bif.CRC, held);
        end

        // Asynchronous reset mid-run, Enable high throughout.
        feed_word(40'hA5_3C_00_00_00, 1'b0);
        check_val("pre_reset_model", bif.CRC, ref_crc());
        bif.Enable = 1'b1;
        bif.BITVAL = 1'b1;
        #2;
        RST_IN = 1'b1;
        #1;
        check_val("reset_async", bif.CRC, 7'h00);
        repeat (2) clk_bit(1'b1, 1'b1);
        check_val("reset_dominates_enable", bif.CRC, 7'h00);
        do_reset();
        clk_bit(1'b1, 1'b1);
        check_val("restart_after_reset", bif.CRC, 7'h09);

        do_reset();
        feed_word(40'h00_00_00_00_00, 1'b0);
        check_val("all_zero", bif.CRC, 7'h00);

        do_reset();
        feed_word(40'h40_00_00_00_00, 1'b0);
        check_val("cmd0", bif.CRC, 7'h4A);
        check_val("cmd0_model", bif.CRC, ref_crc());

        do_reset();
        feed_word(40'h51_00_00_00_00, 1'b1);
        check_val("cmd17_gaps", bif.CRC, 7'h2A);

        do_reset();
        feed_word(40'h48_00_00_01_AA, 1'b0);
        check_val("cmd8", bif.CRC, 7'h43);
        check_val("cmd8_model", bif.CRC, ref_crc());

        do_reset();
        feed_word(40'h48_00_00_01_AA, 1'b1);
        check_val("cmd8_gaps", bif.CRC, 7'h43);

        // Message followed by its own CRC leaves zero.
        do_reset();
        feed_word(40'h40_00_00_00_00, 1'b1);
        seven = 7'b1001010;
        for (int i = 6; i >= 0; i--) feed_bit(seven[i], 1'b1);
        check_val("cmd0_selfcheck", bif.CRC, 7'h00);

        // Random messages with random enable gaps, checked bit by bit and with CRC appended.
        for (int m = 0; m < 20; m++) begin
            do_reset();
            len = $urandom_range(1, 64);
            for (int i = 0; i < len; i++) begin
                feed_bit(1'($urandom), 1'b1);
                check_val("rand_bit", bif.CRC, ref_crc());
            end
            seven = ref_crc();
            for (int i = 6; i >= 0; i--) feed_bit(seven[i], 1'b1);
            check_val("rand_selfcheck", bif.CRC, 7'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_crc7_gen.md
Name: sd_crc7_gen

Overview:
- Bit-serial CRC-7 generator/checker for the SD command line, using polynomial x^7 + x^3 + 1.
- The command serial host feeds it one bit per SD clock while it transmits the 40 command/argument bits or receives response bits.
- The host sends the resulting 7-bit CRC on the command line, or compares it against the received CRC field.
- Purely sequential shift register with enable and reset; no handshake.

Parameters:
- none (polynomial and 7-bit width are fixed)

Ports:
- SD_CLK_IN  input  1  SD clock; all state updates on its rising edge
- RST_IN  input  1  reset, asynchronous, active-high; clears CRC register
- BITVAL  input  1  serial data bit to fold into the CRC (MSB of the message first)
- Enable  input  1  when high, BITVAL is consumed on the next rising edge; when low, CRC holds
- CRC  output  7  current CRC remainder, registered; CRC[6] is the MSB (first bit transmitted)

Behaviour:
- Reset: while RST_IN is high, CRC = 7'b0000000 immediately, without waiting for a clock edge.
  - RST_IN dominates Enable.
  - The host drives RST_IN high in idle/delay states, so each command starts from 0.
- Rising edge of SD_CLK_IN with RST_IN low and Enable high:
  - inv = BITVAL XOR CRC[6]
  - CRC[6] <= CRC[5]
  - CRC[5] <= CRC[4]
  - CRC[4] <= CRC[3]
  - CRC[3] <= CRC[2] XOR inv
  - CRC[2] <= CRC[1]
  - CRC[1] <= CRC[0]
  - CRC[0] <= inv
- Rising edge with Enable low: CRC holds its value.
- Latency: one clock per bit. After N enabled edges, CRC equals the CRC-7 of the N bits presented, MSB first, with zero initial value and no augmentation or final XOR.
- CRC is a direct register output: no combinational path from BITVAL or Enable to CRC.
- Reset mid-stream: CRC clears at once. Accumulation restarts from 0 on the first enabled edge after RST_IN deasserts.
- An all-zero message leaves CRC at 0.
- A message followed by its own 7-bit CRC leaves CRC = 0. The host may compare the received CRC bits directly against CRC after feeding only message bits.

Test Plan:
1. Reset: assert RST_IN mid-run with CRC nonzero -> CRC = 0x00 before the next clock edge; Enable high during reset has no effect.
2. Single bit: from 0, feed BITVAL=1 for one enabled edge -> CRC = 0x09; then BITVAL=0 for one edge -> CRC = 0x12.
3. Hold: with Enable=0, toggle BITVAL over 10 edges -> CRC unchanged.
4. CMD0: feed the 40 bits 0x40_00_00_00_00 MSB first -> CRC = 0x4A (transmitted byte with stop bit = 0x95).
5. CMD17 and CMD8:
   - 0x51_00_00_00_00 -> CRC = 0x2A (byte 0x55).
   - 0x48_00_00_01_AA -> CRC = 0x43 (byte 0x87).
6. Self-check: feed 0x40_00_00_00_00 followed by its CRC bits 1001010 -> CRC = 0x00. Enable gaps inserted between bits do not change the results.
